uart_rx_word_assembler: RTL and testbench
=========================================

# uart_rx_word_assembler

Parametrised successor to the UART receive word buffer: packs a stream of received UART bytes into words of configurable width and byte order for the RISC-V instruction/data loader. Adds a registered output word with valid/ready handshake, and an inter-byte timeout that discards partial words. Also adds a sticky overflow flag for words lost while the consumer stalls. Sits between the UART RX byte receiver and the instruction memory write port.

## Interface
- BYTES_PER_WORD, 4: bytes per assembled word; legal 2..8
- BYTE_W, 8: bits per received byte
- LSB_FIRST, 0: 0 = first byte lands in the most significant byte; 1 = first byte lands in the least significant byte
- TIMEOUT_CYCLES, 1_000_000: idle clocks after which a partial word is discarded; 0 disables the timeout
- clk_100MHz  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- byte_valid  in  1  one-cycle strobe; byte_data is valid
- byte_data  in  BYTE_W  received byte
- word_data  out  BYTES_PER_WORD*BYTE_W  assembled word; held stable while word_valid=1
- word_valid  out  1  word_data holds an unconsumed word
- word_ready  in  1  consumer accepts word_data this cycle
- byte_count  out  clog2(BYTES_PER_WORD+1)  bytes in the current partial word, 0..BYTES_PER_WORD-1
- partial_abort  out  1  one-cycle pulse; a partial word was discarded by the timeout
- overflow  out  1  sticky; a completed word was dropped
- clr_overflow  in  1  clears overflow

## Operation
- Reset values: word_data=0, word_valid=0, byte_count=0, partial_abort=0, overflow=0. The assembly register and the idle counter also reset to 0.
- Each byte_valid cycle writes byte_data into the assembly register slot selected by byte_count and LSB_FIRST:
  - LSB_FIRST=0: slot BYTES_PER_WORD-1-byte_count.
  - LSB_FIRST=1: slot byte_count.
- If the byte is not the last one, byte_count increments.
- On the last byte (byte_count == BYTES_PER_WORD-1), the full word (assembly register plus the incoming byte) is the completed word and byte_count returns to 0.
- Completion when the output is free (word_valid=0, or word_valid & word_ready in the same cycle): the completed word loads word_data and word_valid=1.
- Completion when the output is stalled (word_valid=1 & word_ready=0): the completed word is discarded, word_data is unchanged and overflow is set. Assembly restarts at byte 0.
- Consume: word_valid & word_ready with no completion in the same cycle -> word_valid=0 on the next cycle. word_data retains its last value.
- Timeout:
  - The idle counter clears on every byte_valid and whenever byte_count=0.
  - Otherwise it increments while byte_count>0.
  - When it reaches TIMEOUT_CYCLES: byte_count=0, assembly register=0, partial_abort pulses for one cycle, and the idle counter clears.
- byte_valid in the same cycle the timeout fires: the byte wins. It is accepted normally and no abort occurs.
- clr_overflow clears overflow. If clr_overflow coincides with a new overflow event, overflow stays set.
- Mid-operation reset asynchronously clears all state, including any pending word.

## Timing
- Latency: last byte sampled at edge k -> word_valid=1 and word_data valid after edge k (visible in cycle k+1).
- Throughput: one byte per clock is sustained. A word can be presented every BYTES_PER_WORD cycles if word_ready is held high.
- word_valid is never withdrawn without a handshake. word_data changes only on a load.
- byte_count, overflow and partial_abort are registered outputs.
- The handshake has no combinational path from word_ready to word_valid.

## Structure
- Shared package uart_soc_pkg holds:
  - UART_BYTE_W = 8
  - the default BYTES_PER_WORD
  - the default TIMEOUT_CYCLES, derived from the 100 MHz clock
- Sub-module uart_rx_idle_timer: parametrised down-counter with clear/enable inputs and an expire pulse output. It is reused by the UART receiver.
- The rest (slot write, byte counter, output register, flags) stays in a single module.

## Test plan
- Default params, word_ready=1, bytes 0x13,0x05,0x10,0x00 -> word_data=0x13051000, word_valid high for 1 cycle; byte_count walks 0,1,2,3,0.
- LSB_FIRST=1, same bytes -> word_data=0x00100513. Then 8 back-to-back bytes with word_ready=1 -> two words, each valid 1 cycle after its 4th byte.
- word_ready=0, send 8 bytes 0x01..0x08 -> word_data stays 0x01020304, overflow=1. Pulse clr_overflow -> overflow=0. Raise word_ready -> one transfer of 0x01020304.
- TIMEOUT_CYCLES=16, send 0xAA,0xBB, then idle -> partial_abort pulses exactly 16 cycles after the 0xBB strobe, byte_count=0. Next 4 bytes 0x11..0x14 -> 0x11121314.
- word_valid=1 with word_ready asserted in the same cycle a new 4th byte arrives -> new word loads, word_valid stays 1, overflow stays 0.
- Assert rst after 2 bytes while a word is pending -> all outputs 0 immediately. The next 4 bytes form a clean word.

Source files
------------

// File: rtl/uart_soc_pkg.sv
// Shared UART SoC constants: byte width, default word size and the idle timeout
// derived from the 100 MHz system clock.
package uart_soc_pkg;
  localparam int UART_BYTE_W            = 8;
  localparam int DEFAULT_BYTES_PER_WORD = 4;
  localparam int SYS_CLK_HZ             = 100_000_000;
  // 10 ms of line silence abandons a partial word
  localparam int DEFAULT_TIMEOUT_CYCLES = SYS_CLK_HZ / 100;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_rx_idle_timer.sv
// Idle down-counter: clr reloads, en counts down, expire pulses (combinationally)
// on the enabled cycle that would go below zero. CYCLES=0 disables it.
module uart_rx_idle_timer
  import uart_soc_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  generate
    if (CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_cnt
      localparam int            W    = cnt_w(CYCLES);
      localparam logic [W-1:0]  LOAD = W'(CYCLES - 1);
      logic [W-1:0] cnt;

      // clr always wins, so a byte arriving on the expiry cycle suppresses the abort
      assign expire = en && !clr && (cnt == '0);

      always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (clr || expire) cnt <= LOAD;
        else if (en)            cnt <= cnt - 1'b1;
      end
    end
  endgenerate
endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes into words with a registered valid/ready output,
// inter-byte timeout abort and a sticky overflow flag for words dropped on stall.
module uart_rx_word_assembler
  import uart_soc_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
  parameter int BYTE_W         = UART_BYTE_W,
  parameter int LSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                   clk_100MHz,
  input  logic                                   rst,
  input  logic                                   byte_valid,
  input  logic [BYTE_W-1:0]                      byte_data,
  output logic [BYTES_PER_WORD*BYTE_W-1:0]       word_data,
  output logic                                   word_valid,
  input  logic                                   word_ready,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]    byte_count,
  output logic                                   partial_abort,
  output logic                                   overflow,
  input  logic                                   clr_overflow
);
  localparam int             CW   = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CW-1:0]  LAST = CW'(BYTES_PER_WORD - 1);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] asm_q, full;
  logic [CW-1:0] slot;
  logic          is_last, out_free, expire, timer_clr, timer_en;

  assign slot      = (LSB_FIRST != 0) ? byte_count : LAST - byte_count;
  assign is_last   = byte_valid && (byte_count == LAST);
  assign out_free  = !word_valid || word_ready;
  assign timer_clr = byte_valid || (byte_count == '0);
  assign timer_en  = (byte_count != '0);

  // assembly register with the incoming byte merged into its slot
  always_comb begin
    full       = asm_q;
    full[slot] = byte_data;
  end

  uart_rx_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .clr        (timer_clr),
    .en         (timer_en),
    .expire     (expire)
  );

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      asm_q         <= '0;
      byte_count    <= '0;
      word_data     <= '0;
      word_valid    <= 1'b0;
      partial_abort <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      partial_abort <= 1'b0;
      if (clr_overflow)              overflow   <= 1'b0;
      if (word_valid && word_ready)  word_valid <= 1'b0;
      if (byte_valid) begin
        if (is_last) begin
          byte_count <= '0;
          asm_q      <= '0;
          if (out_free) begin
            word_data  <= full;
            word_valid <= 1'b1;
          end else begin
            overflow   <= 1'b1;
          end
        end else begin
          asm_q      <= full;
          byte_count <= byte_count + 1'b1;
        end
      end else if (expire) begin
        byte_count    <= '0;
        asm_q         <= '0;
        partial_abort <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench: three assembler instances (default, LSB-first, short timeout)
// on shared stimulus; each task resets and checks the instance it targets.
module tb_uart_rx_word_assembler;
  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        word_ready = 1'b0;
  logic        clr_overflow = 1'b0;

  logic [31:0] a_wd, l_wd, t_wd;
  logic        a_wv, l_wv, t_wv;
  logic [2:0]  a_bc, l_bc, t_bc;
  logic        a_pa, l_pa, t_pa;
  logic        a_ov, l_ov, t_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_rx_word_assembler u_def (
    .clk_100MHz(clk_100MHz), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .word_data(a_wd), .word_valid(a_wv), .word_ready(word_ready), .byte_count(a_bc),
    .partial_abort(a_pa), .overflow(a_ov), .clr_overflow(clr_overflow));

  uart_rx_word_assembler #(.LSB_FIRST(1)) u_lsb (
    .clk_100MHz(clk_100MHz), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .word_data(l_wd), .word_valid(l_wv), .word_ready(word_ready), .byte_count(l_bc),
    .partial_abort(l_pa), .overflow(l_ov), .clr_overflow(clr_overflow));

  uart_rx_word_assembler #(.TIMEOUT_CYCLES(16)) u_to (
    .clk_100MHz(clk_100MHz), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .word_data(t_wd), .word_valid(t_wv), .word_ready(word_ready), .byte_count(t_bc),
    .partial_abort(t_pa), .overflow(t_ov), .clr_overflow(clr_overflow));

  // drive on negedge, outputs inspected 1 ns after the following posedge
  task automatic tick(input logic v, input logic [7:0] d);
    @(negedge clk_100MHz);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk_100MHz);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    rst = 1'b1;
    @(negedge clk_100MHz);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_100MHz);
    rst = 1'b1;
    #1;
    checks++; if (a_wd !== 32'h0) begin errors++; $display("FAIL reset word_data got %h want 0", a_wd); end
    checks++; if (a_wv !== 1'b0)  begin errors++; $display("FAIL reset word_valid got %b want 0", a_wv); end
    checks++; if (a_bc !== 3'd0)  begin errors++; $display("FAIL reset byte_count got %0d want 0", a_bc); end
    checks++; if (a_pa !== 1'b0)  begin errors++; $display("FAIL reset partial_abort got %b want 0", a_pa); end
    checks++; if (a_ov !== 1'b0)  begin errors++; $display("FAIL reset overflow got %b want 0", a_ov); end
    @(negedge clk_100MHz);
    rst = 1'b0;
  endtask

  task automatic test_msb_word();
    logic [7:0] b  [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    logic [2:0] bc [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, b[i]);
      checks++; if (a_bc !== bc[i]) begin errors++; $display("FAIL msb byte_count[%0d] got %0d want %0d", i, a_bc, bc[i]); end
    end
    checks++; if (a_wv !== 1'b1) begin errors++; $display("FAIL msb word_valid got %b want 1", a_wv); end
    checks++; if (a_wd !== 32'h13051000) begin errors++; $display("FAIL msb word_data got %h want 13051000", a_wd); end
    tick(1'b0, 8'h00);
    checks++; if (a_wv !== 1'b0) begin errors++; $display("FAIL msb valid_one_cycle got %b want 0", a_wv); end
    checks++; if (a_wd !== 32'h13051000) begin errors++; $display("FAIL msb data_hold got %h want 13051000", a_wd); end
    word_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    logic       ev;
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, b[i]);
    checks++; if (l_wd !== 32'h00100513) begin errors++; $display("FAIL lsb word_data got %h want 00100513", l_wd); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'hA0 + 8'(i));
      ev = (i == 3) || (i == 7);
      checks++; if (l_wv !== ev) begin errors++; $display("FAIL b2b word_valid[%0d] got %b want %b", i, l_wv, ev); end
      if (i == 3) begin
        checks++; if (l_wd !== 32'hA3A2A1A0) begin errors++; $display("FAIL b2b word0 got %h want A3A2A1A0", l_wd); end
      end
      if (i == 7) begin
        checks++; if (l_wd !== 32'hA7A6A5A4) begin errors++; $display("FAIL b2b word1 got %h want A7A6A5A4", l_wd); end
      end
    end
    tick(1'b0, 8'h00);
    checks++; if (l_wv !== 1'b0) begin errors++; $display("FAIL b2b drain got %b want 0", l_wv); end
    checks++; if (l_ov !== 1'b0) begin errors++; $display("FAIL b2b overflow got %b want 0", l_ov); end
    word_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 8'(i));
      if (i == 4) begin
        checks++; if (a_wv !== 1'b1) begin errors++; $display("FAIL ovf first_valid got %b want 1", a_wv); end
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL ovf early_flag got %b want 0", a_ov); end
      end
    end
    checks++; if (a_wd !== 32'h01020304) begin errors++; $display("FAIL ovf word_kept got %h want 01020304", a_wd); end
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL ovf flag got %b want 1", a_ov); end
    checks++; if (a_bc !== 3'd0) begin errors++; $display("FAIL ovf byte_count got %0d want 0", a_bc); end
    clr_overflow = 1'b1;
    tick(1'b0, 8'h00);
    clr_overflow = 1'b0;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL ovf clear got %b want 0", a_ov); end
    checks++; if (a_wv !== 1'b1) begin errors++; $display("FAIL ovf still_pending got %b want 1", a_wv); end
    word_ready = 1'b1;
    tick(1'b0, 8'h00);
    word_ready = 1'b0;
    checks++; if (a_wv !== 1'b0) begin errors++; $display("FAIL ovf consumed got %b want 0", a_wv); end
    checks++; if (a_wd !== 32'h01020304) begin errors++; $display("FAIL ovf data_after got %h want 01020304", a_wd); end
  endtask

  task automatic test_timeout();
    logic       epa;
    logic [2:0] ebc;
    do_reset();
    word_ready = 1'b1;
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    checks++; if (t_bc !== 3'd2) begin errors++; $display("FAIL to partial_count got %0d want 2", t_bc); end
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 8'h00);
      epa = (i == 16);
      ebc = (i == 16) ? 3'd0 : 3'd2;
      checks++; if (t_pa !== epa) begin errors++; $display("FAIL to abort[%0d] got %b want %b", i, t_pa, epa); end
      checks++; if (t_bc !== ebc) begin errors++; $display("FAIL to count[%0d] got %0d want %0d", i, t_bc, ebc); end
    end
    tick(1'b0, 8'h00);
    checks++; if (t_pa !== 1'b0) begin errors++; $display("FAIL to pulse_width got %b want 0", t_pa); end
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h11 + 8'(i));
    checks++; if (t_wd !== 32'h11121314) begin errors++; $display("FAIL to next_word got %h want 11121314", t_wd); end
    checks++; if (t_wv !== 1'b1) begin errors++; $display("FAIL to next_valid got %b want 1", t_wv); end
    // byte landing on the expiry cycle must be kept
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00);
    tick(1'b1, 8'hCC);
    checks++; if (t_pa !== 1'b0) begin errors++; $display("FAIL to byte_wins_abort got %b want 0", t_pa); end
    checks++; if (t_bc !== 3'd3) begin errors++; $display("FAIL to byte_wins_count got %0d want 3", t_bc); end
    tick(1'b1, 8'hDD);
    checks++; if (t_wd !== 32'hAABBCCDD) begin errors++; $display("FAIL to byte_wins_word got %h want AABBCCDD", t_wd); end
    word_ready = 1'b0;
  endtask

  task automatic test_simul_load();
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 4; i++) tick(1'b1, 8'(i));
    for (int i = 1; i <= 3; i++) tick(1'b1, 8'h20 + 8'(i));
    checks++; if (a_bc !== 3'd3) begin errors++; $display("FAIL sim count got %0d want 3", a_bc); end
    word_ready = 1'b1;
    tick(1'b1, 8'h24);
    checks++; if (a_wv !== 1'b1) begin errors++; $display("FAIL sim valid got %b want 1", a_wv); end
    checks++; if (a_wd !== 32'h21222324) begin errors++; $display("FAIL sim word got %h want 21222324", a_wd); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL sim overflow got %b want 0", a_ov); end
    tick(1'b0, 8'h00);
    checks++; if (a_wv !== 1'b0) begin errors++; $display("FAIL sim drain got %b want 0", a_wv); end
    word_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 10; i++) tick(1'b1, 8'(i));
    checks++; if (a_bc !== 3'd2) begin errors++; $display("FAIL mrst pre_count got %0d want 2", a_bc); end
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL mrst pre_ovf got %b want 1", a_ov); end
    @(negedge clk_100MHz);
    rst = 1'b1;
    #1;
    checks++; if (a_wd !== 32'h0) begin errors++; $display("FAIL mrst word_data got %h want 0", a_wd); end
    checks++; if (a_wv !== 1'b0)  begin errors++; $display("FAIL mrst word_valid got %b want 0", a_wv); end
    checks++; if (a_bc !== 3'd0)  begin errors++; $display("FAIL mrst byte_count got %0d want 0", a_bc); end
    checks++; if (a_ov !== 1'b0)  begin errors++; $display("FAIL mrst overflow got %b want 0", a_ov); end
    @(negedge clk_100MHz);
    rst = 1'b0;
    word_ready = 1'b1;
    for (int i = 1; i <= 4; i++) tick(1'b1, 8'h30 + 8'(i));
    checks++; if (a_wd !== 32'h31323334) begin errors++; $display("FAIL mrst clean_word got %h want 31323334", a_wd); end
    checks++; if (a_wv !== 1'b1) begin errors++; $display("FAIL mrst clean_valid got %b want 1", a_wv); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mrst clean_ovf got %b want 0", a_ov); end
    word_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_simul_load();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
